// File: rtl/rand_synch_stream_sink.sv
// Randomizing synchronous stream receiver.
// Accepts beats on a valid/ready port, raising ready after a pseudo-random
// number of idle cycles, buffers accepted beats in a capture FIFO for the
// surrounding environment to pop, and counts sender protocol violations.
//
// Handshake: a beat transfers in a cycle where valid_i and ready_o are both 1
// at the sample point. Once valid_i is raised without a transfer, the sender
// must keep valid_i high and data_i stable until the transfer happens;
// dropping valid_i or changing data_i in that window is a violation.
//
// Idle-cycle timing: after reset the receiver idles for the drawn count plus
// the reset cycle itself; after a transfer it idles for exactly the drawn
// count, so a draw of 0 gives back-to-back beats. Draws come from a 32-bit
// Galois LFSR folded into [MIN_WAIT_CYCLES, MAX_WAIT_CYCLES].
//
// APPL_DELAY/ACQ_DELAY describe when the environment applies and samples
// signals relative to the clock edge; the logic itself is edge-registered.
module rand_synch_stream_sink #(
  parameter type data_t          = logic,
  parameter int  MIN_WAIT_CYCLES = -1,
  parameter int  MAX_WAIT_CYCLES = -1,
  parameter int  DEPTH           = 16,
  parameter time APPL_DELAY      = 0ps,
  parameter time ACQ_DELAY       = 0ps
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  data_t       data_i,
  output logic        ready_o,
  input  logic        pop_i,
  output data_t       data_o,
  output logic        empty_o,
  output logic        full_o,
  output logic [31:0] beats_o,
  output logic [31:0] err_o
);
  timeunit 1ns;
  timeprecision 1ps;

  if ((MIN_WAIT_CYCLES < 0) || (MAX_WAIT_CYCLES < MIN_WAIT_CYCLES) ||
      (DEPTH < 1) || (ACQ_DELAY <= APPL_DELAY)) begin : g_bad_params
    $fatal(1, "rand_synch_stream_sink: illegal parameter set");
  end

  // Clamped values keep the arithmetic below legal even for a rejected set.
  localparam bit          WAIT_OK   = (MIN_WAIT_CYCLES >= 0) &&
                                      (MAX_WAIT_CYCLES >= MIN_WAIT_CYCLES);
  localparam logic [31:0] MIN_U32   = WAIT_OK ? 32'(MIN_WAIT_CYCLES) : 32'd0;
  localparam logic [31:0] RANGE_U32 = WAIT_OK ? 32'(MAX_WAIT_CYCLES - MIN_WAIT_CYCLES + 1) : 32'd1;
  localparam logic [31:0] SEED      = 32'hACE1_2468;
  localparam logic [31:0] RESET_CNT = MIN_U32 + (SEED % RANGE_U32);
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int DEPTH_S = (DEPTH < 1) ? 1 : DEPTH;
  localparam int PTR_W   = (DEPTH_S > 1) ? $clog2(DEPTH_S) : 1;
  localparam int CNT_W   = $clog2(DEPTH_S + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH_S - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH_S);

  typedef enum logic {S_WAIT, S_RDY} state_t;

  state_t             state;
  logic [31:0]        cnt;
  logic [31:0]        lfsr;
  logic [31:0]        draw;
  data_t              mem [DEPTH_S];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_next;
  logic               full_next;
  logic               valid_x, valid_s, hs, push, pop_ok, pop_err;
  logic               prev_stall;
  data_t              prev_data;
  logic               drop_err, chg_err;
  logic [2:0]         n_err;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [2:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // An unknown valid_i counts as a violation and is treated as 0.
  assign valid_x = (valid_i !== 1'b0) && (valid_i !== 1'b1);
  assign valid_s = valid_i && !valid_x;
  assign ready_o = (state == S_RDY);
  assign hs      = valid_s && ready_o;
  assign push    = hs;
  assign pop_ok  = pop_i && (count != '0);
  assign pop_err = pop_i && (count == '0);
  assign draw    = MIN_U32 + (lfsr % RANGE_U32);

  assign drop_err = prev_stall && !valid_s;
  assign chg_err  = prev_stall && (data_i != prev_data);
  assign n_err    = 3'(pop_err) + 3'(drop_err) + 3'(chg_err) + 3'(valid_x);

  assign data_o  = mem[rd_ptr];
  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);

  // Occupancy after this cycle's push and pop, used to gate the ready FSM.
  always_comb begin
    count_next = count;
    if (push && !pop_ok)      count_next = count + CNT_W'(1);
    else if (!push && pop_ok) count_next = count - CNT_W'(1);
    full_next = (count_next == FULL_CNT);
  end

  // Ready FSM: idle for the drawn count, then offer ready until a transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_WAIT;
      cnt   <= RESET_CNT;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt != '0)      cnt   <= cnt - 32'd1;
          else if (!full_next) state <= S_RDY;
        end
        S_RDY: begin
          if (hs && ((draw != '0) || full_next)) begin
            state <= S_WAIT;
            cnt   <= (draw == '0) ? '0 : draw - 32'd1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  // Free-running pseudo-random source for the wait draws.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr <= SEED;
    else         lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
  end

  // Capture storage; contents are meaningless while empty so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // FIFO pointers and occupancy; pop and push may coincide at any level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
    end
  end

  // Remember whether the sender was stalled last cycle, and with what data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_stall <= 1'b0;
      prev_data  <= '0;
    end else begin
      prev_stall <= valid_s && !ready_o;
      prev_data  <= data_i;
    end
  end

  // Saturating beat and violation counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beats_o <= '0;
      err_o   <= '0;
    end else begin
      if (hs) beats_o <= sat_add(beats_o, 3'd1);
      err_o <= sat_add(err_o, n_err);
    end
  end

endmodule

// File: tb/tb_rand_synch_stream_sink.sv
// Bench for rand_synch_stream_sink: three instances (wait 0 / depth 4,
// wait 3 / depth 8, wait 0 / depth 2) driven by directed per-cycle vectors,
// a per-cycle behavioural model, and hand-computed literal expectations.
module tb_rand_synch_stream_sink;
  timeunit 1ns;
  timeprecision 1ps;

  localparam int NI = 3;

  function automatic int w_of(input int i);
    return (i == 1) ? 3 : 0;
  endfunction

  function automatic int d_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 8 : 2);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        valid_v [NI];
  logic        pop_v   [NI];
  logic [7:0]  din     [NI];
  logic        ready_v [NI];
  logic        empty_v [NI];
  logic        full_v  [NI];
  logic [7:0]  dout    [NI];
  logic [31:0] beats   [NI];
  logic [31:0] errs    [NI];

  int vectors     = 0;
  int miscompares = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    rand_synch_stream_sink #(
      .data_t          (logic [7:0]),
      .MIN_WAIT_CYCLES (w_of(g)),
      .MAX_WAIT_CYCLES (w_of(g)),
      .DEPTH           (d_of(g)),
      .APPL_DELAY      (2ns),
      .ACQ_DELAY       (8ns)
    ) u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .valid_i (valid_v[g]),
      .data_i  (din[g]),
      .ready_o (ready_v[g]),
      .pop_i   (pop_v[g]),
      .data_o  (dout[g]),
      .empty_o (empty_v[g]),
      .full_o  (full_v[g]),
      .beats_o (beats[g]),
      .err_o   (errs[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // Ready is high once the required idle cycles have elapsed and the FIFO
  // has room; the reset cycle is one extra idle cycle.
  logic [7:0]  exp_q   [NI][$];
  int          m_idle  [NI];
  logic [31:0] m_beats [NI];
  logic [31:0] m_err   [NI];
  bit          m_stall [NI];
  logic [7:0]  m_pdata [NI];

  task automatic model_cycle(input int i);
    bit rdy, hs, pop_ok;
    int e;
    longint s;
    if (!rst_n) begin
      exp_q[i].delete();
      m_idle[i]  = w_of(i) + 1;
      m_beats[i] = 0;
      m_err[i]   = 0;
      m_stall[i] = 0;
      m_pdata[i] = 0;
    end
    rdy = rst_n && (m_idle[i] == 0) && (exp_q[i].size() < d_of(i));
    check($sformatf("i%0d_ready", i), 32'(ready_v[i]), 32'(rdy));
    check($sformatf("i%0d_empty", i), 32'(empty_v[i]), 32'(exp_q[i].size() == 0));
    check($sformatf("i%0d_full", i),  32'(full_v[i]),  32'(exp_q[i].size() == d_of(i)));
    check($sformatf("i%0d_beats", i), beats[i], m_beats[i]);
    check($sformatf("i%0d_err", i),   errs[i],  m_err[i]);
    if (exp_q[i].size() > 0)
      check($sformatf("i%0d_head", i), 32'(dout[i]), 32'(exp_q[i][0]));
    if (!rst_n) return;
    e = 0;
    if (m_stall[i] && !valid_v[i])            e++;
    if (m_stall[i] && (din[i] != m_pdata[i])) e++;
    hs     = valid_v[i] && rdy;
    pop_ok = pop_v[i] && (exp_q[i].size() > 0);
    if (pop_v[i] && !pop_ok) e++;
    if (pop_ok) void'(exp_q[i].pop_front());
    if (hs) begin
      exp_q[i].push_back(din[i]);
      if (m_beats[i] != 32'hFFFF_FFFF) m_beats[i]++;
    end
    s = longint'(m_err[i]) + e;
    m_err[i] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    if (hs)                       m_idle[i] = w_of(i);
    else if (!rdy && m_idle[i] > 0) m_idle[i]--;
    m_stall[i] = valid_v[i] && !rdy;
    m_pdata[i] = din[i];
  endtask

  // Compare process: outputs and inputs both taken at the sample point.
  initial begin
    forever begin
      @(posedge clk);
      #8;
      for (int i = 0; i < NI; i++) model_cycle(i);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      valid_v[i] = 1'b0;
      pop_v[i]   = 1'b0;
    end
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  // Wait 3 protocol vectors {valid, data} for instance 1.
  logic [8:0] tbl_c [10] = '{9'h110, 9'h120, 9'h020, 9'h130, 9'h130,
                             9'h140, 9'h141, 9'h141, 9'h141, 9'h041};
  // Depth 2 vectors {valid, data, pop} for instance 2.
  logic [9:0] tbl_d [7]  = '{10'h2A2, 10'h2A5, 10'h2A6, 10'h2A8, 10'h2A9,
                             10'h2A8, 10'h0A8};
  logic [7:0] heads_c [4] = '{8'hA5, 8'h10, 8'h30, 8'h41};

  // ---------------- main stimulus ----------------
  initial begin
    int n;
    bit hs;
    logic [8:0] hist;
    for (int i = 0; i < NI; i++) begin
      valid_v[i] = 1'b0;
      pop_v[i]   = 1'b0;
      din[i]     = 8'h00;
    end
    #1 rst_n = 1'b0;
    #2;
    check("rst_ready", 32'(ready_v[0]), 32'd0);
    check("rst_empty", 32'(empty_v[0]), 32'd1);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Wait 0, depth 4: back-to-back beats until full.
    valid_v[0] = 1'b1;
    n = 1;
    din[0] = 8'(n);
    for (int k = 0; k < 8; k++) begin
      hs = ready_v[0];
      cyc();
      if (hs) begin n++; din[0] = 8'(n); end
    end
    check("a_beats", beats[0], 32'd4);
    check("a_full",  32'(full_v[0]),  32'd1);
    check("a_ready", 32'(ready_v[0]), 32'd0);
    for (int v = 1; v <= 4; v++) begin
      check("a_fifo", 32'(dout[0]), 32'(v));
      pop_v[0] = 1'b1;
      hs = ready_v[0];
      cyc();
      if (hs) begin n++; din[0] = 8'(n); end
    end
    pop_v[0] = 1'b0;

    // Wait 3: ready rises in cycle 4 after reset, then idles 3 cycles.
    do_reset();
    valid_v[1] = 1'b1;
    din[1] = 8'hA5;
    for (int k = 0; k < 9; k++) begin
      hist[k] = ready_v[1];
      cyc();
      if (k == 4) valid_v[1] = 1'b0;
    end
    check("b_ready_trace", 32'(hist), 32'h110);
    check("b_head",  32'(dout[1]), 32'hA5);
    check("b_beats", beats[1], 32'd1);

    // Protocol violations while stalled: dropped valid, then changed data.
    for (int k = 0; k < 10; k++) begin
      {valid_v[1], din[1]} = tbl_c[k];
      if (k == 3) check("c_err_drop",   errs[1], 32'd1);
      if (k == 7) check("c_err_change", errs[1], 32'd2);
      cyc();
    end
    check("c_beats", beats[1], 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("c_fifo", 32'(dout[1]), 32'(heads_c[k]));
      pop_v[1] = 1'b1;
      cyc();
    end
    check("c_empty_before", 32'(empty_v[1]), 32'd1);
    cyc();
    pop_v[1] = 1'b0;
    check("c_err_pop_empty", errs[1], 32'd3);
    check("c_empty_after",   32'(empty_v[1]), 32'd1);

    // Depth 2: simultaneous push/pop, fill, pop from full.
    for (int k = 0; k < 7; k++) begin
      {valid_v[2], din[2], pop_v[2]} = tbl_d[k];
      if (k == 2) begin
        check("d_head_pushpop", 32'(dout[2]), 32'h52);
        check("d_beats2", beats[2], 32'd2);
        check("d_notfull", 32'(full_v[2]), 32'd0);
      end
      if (k == 3) begin
        check("d_full", 32'(full_v[2]), 32'd1);
        check("d_ready_full", 32'(ready_v[2]), 32'd0);
      end
      if (k == 5) begin
        check("d_ready_again", 32'(ready_v[2]), 32'd1);
        check("d_head_after_pop", 32'(dout[2]), 32'h53);
      end
      cyc();
    end
    pop_v[2] = 1'b0;
    check("d_beats", beats[2], 32'd4);
    check("d_full_end", 32'(full_v[2]), 32'd1);
    check("d_err", errs[2], 32'd0);

    // Reset mid-burst with 3 beats queued.
    valid_v[0] = 1'b1;
    din[0] = 8'h61;
    cyc();
    din[0] = 8'h62;
    cyc();
    din[0] = 8'h63;
    cyc();
    din[0] = 8'h64;
    check("e_beats_pre", beats[0], 32'd3);
    rst_n = 1'b0;
    #1;
    check("e_rst_ready", 32'(ready_v[0]), 32'd0);
    check("e_rst_empty", 32'(empty_v[0]), 32'd1);
    check("e_rst_beats", beats[0], 32'd0);
    check("e_rst_err",   errs[0],  32'd0);
    #1;
    do_reset();
    valid_v[0] = 1'b1;
    din[0] = 8'h71;
    for (int k = 0; k < 3; k++) begin
      hs = ready_v[0];
      cyc();
      if (hs) begin
        if (din[0] == 8'h71) din[0] = 8'h72;
        else valid_v[0] = 1'b0;
      end
    end
    check("e_beats_post", beats[0], 32'd2);
    check("e_head_post",  32'(dout[0]), 32'h71);
    check("e_err_post",   errs[0], 32'd0);

    cyc();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    miscompares++;
    $display("FAIL watchdog: run did not complete, expected completion before %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
